nibble_serial_compare: RTL and testbench

- Iterative wide-word magnitude comparator built around a single 4-bit compare slice with lt/eq/gt cascade semantics.
- Accepts two WIDTH-bit operands plus cascade inputs over a valid/ready handshake.
- Scans nibbles MSB-first, one nibble per clock, stopping at the first differing nibble.
- Returns one-hot lt/eq/gt with a nibble-count over a second valid/ready handshake. It feeds downstream compare-result consumers in the same datapath.

---
 rtl/nibble_serial_compare.sv | 124 ++++++++++++
 tb/tb_nibble_serial_compare.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_compare.sv
// Iterative WIDTH-bit magnitude comparator: one 4-bit compare slice scans the
// operands MSB-first and stops at the first differing nibble. Cascade inputs
// resolve the fully-equal case.
module nibble_serial_compare #(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4,
  localparam int CW    = $clog2(NIB + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             casc_lt_in,
  input  logic             casc_eq_in,
  input  logic             casc_gt_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       casc_q, casc_d;   // {lt, eq, gt}
  logic [2:0]       res_q, res_d;     // {lt, eq, gt}
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       nib_a, nib_b;

  // Current nibble pair selected by the scan index.
  assign nib_a = 4'(a_q >> {idx_q, 2'b00});
  assign nib_b = 4'(b_q >> {idx_q, 2'b00});

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    casc_d  = casc_q;
    res_d   = res_q;
    idx_d   = idx_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          casc_d  = {casc_lt_in, casc_eq_in, casc_gt_in};
          idx_d   = IW'(NIB - 1);
          count_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        count_d = count_q + 1'b1;
        if (nib_a != nib_b) begin
          res_d   = (nib_a > nib_b) ? 3'b001 : 3'b100;
          state_d = DONE;
        end else if (idx_q == '0) begin
          // Equal words: eq wins, then gt, then lt; no cascade input means equal.
          if (casc_q[1])      res_d = 3'b010;
          else if (casc_q[0]) res_d = 3'b001;
          else if (casc_q[2]) res_d = 3'b100;
          else                res_d = 3'b010;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides both the accept and the output handshake.
    if (flush) begin
      res_d   = '0;
      state_d = IDLE;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  assign in_ready     = (state_q == IDLE) && !rst;
  assign out_valid    = (state_q == DONE);
  assign {lt, eq, gt} = res_q;
  assign cycles       = count_q;

endmodule

// File: tb/tb_nibble_serial_compare.sv
// Directed bench for nibble_serial_compare (WIDTH=16) with hand-computed
// expected results, latencies and handshake timing.
module tb_nibble_serial_compare;

  localparam int WIDTH = 16;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             casc_lt_in, casc_eq_in, casc_gt_in;
  logic             flush;
  logic             out_valid, out_ready;
  logic             lt, eq, gt;
  logic [CW-1:0]    cycles;

  int n_vec  = 0;
  int n_miss = 0;

  nibble_serial_compare #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .casc_lt_in (casc_lt_in),
    .casc_eq_in (casc_eq_in),
    .casc_gt_in (casc_gt_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .lt         (lt),
    .eq         (eq),
    .gt         (gt),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for a single accept edge; casc is {lt, eq, gt}.
  task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] casc);
    a = va;
    b = vb;
    {casc_lt_in, casc_eq_in, casc_gt_in} = casc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hxxxx;
    b = 16'hxxxx;
  endtask

  // Edges from accept until out_valid, bounded so a stuck DUT still reports.
  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [2:0] casc, input logic [2:0] exp_res, input int exp_k);
    int k;
    start_op(va, vb, casc);
    wait_valid(k);
    check({tag, " latency"}, k, exp_k);
    check({tag, " result"}, {lt, eq, gt}, exp_res);
    check({tag, " cycles"}, cycles, exp_k);
    pop();
    check({tag, " after pop"}, {out_valid, in_ready, lt, eq, gt}, 5'b01000);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    a = '0;
    b = '0;
    {casc_lt_in, casc_eq_in, casc_gt_in} = 3'b000;
    #1;
    check("reset outputs", {out_valid, in_ready, lt, eq, gt}, 5'b00000);
    check("reset cycles", cycles, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("ready after reset", in_ready, 1);

    // First nibble differs: one-cycle latency.
    run_case("msb diff", 16'h8000, 16'h7FFF, 3'b010, 3'b001, 1);
    check("cycles kept in idle", cycles, 1);

    // Last nibble differs; result must hold while out_ready stays low.
    start_op(16'h1234, 16'h1235, 3'b010);
    wait_valid(k);
    check("lsb diff latency", k, 4);
    for (int i = 0; i < 5; i++) begin
      check("hold valid", out_valid, 1);
      check("hold result", {lt, eq, gt}, 3'b100);
      check("hold cycles", cycles, 4);
      check("hold in_ready", in_ready, 0);
      tick();
    end
    pop();
    check("lsb diff popped", {out_valid, in_ready}, 2'b01);

    // Equal operands: cascade resolution.
    run_case("casc 010", 16'hBEEF, 16'hBEEF, 3'b010, 3'b010, 4);
    run_case("casc 001", 16'hBEEF, 16'hBEEF, 3'b001, 3'b001, 4);
    run_case("casc 100", 16'hBEEF, 16'hBEEF, 3'b100, 3'b100, 4);
    run_case("casc 000", 16'hBEEF, 16'hBEEF, 3'b000, 3'b010, 4);
    run_case("casc 011", 16'hBEEF, 16'hBEEF, 3'b011, 3'b010, 4);

    // Back-to-back with in_valid held high.
    a = 16'h00F0;
    b = 16'h0100;
    {casc_lt_in, casc_eq_in, casc_gt_in} = 3'b010;
    in_valid = 1'b1;
    tick();
    check("b2b accept1 ready", in_ready, 0);
    tick();
    check("b2b scan", {out_valid, in_ready}, 2'b00);
    tick();
    check("b2b done valid", {out_valid, in_ready}, 2'b10);
    check("b2b result", {lt, eq, gt}, 3'b100);
    check("b2b cycles", cycles, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b idle cycle", {out_valid, in_ready}, 2'b01);
    tick();
    check("b2b accept2", in_ready, 0);
    in_valid = 1'b0;
    wait_valid(k);
    check("b2b second latency", k, 2);
    check("b2b second result", {lt, eq, gt, 1'b0, cycles}, {3'b100, 1'b0, 3'd2});
    pop();

    // Flush during the second SCAN cycle.
    start_op(16'h0000, 16'h0000, 3'b010);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush to idle", {out_valid, in_ready, lt, eq, gt}, 5'b01000);
    for (int i = 0; i < 5; i++) begin
      check("no result after flush", out_valid, 0);
      tick();
    end
    run_case("post flush", 16'h0001, 16'h0000, 3'b010, 3'b001, 4);

    // Async reset pulsed mid-DONE.
    start_op(16'h8000, 16'h7FFF, 3'b010);
    wait_valid(k);
    check("pre-reset valid", {out_valid, gt}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("async reset drop", {out_valid, in_ready, lt, eq, gt}, 5'b00000);
    tick();
    check("ready low in reset", in_ready, 0);
    rst = 1'b0;
    #1;
    check("ready after release", {in_ready, out_valid}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no result after reset", out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
